// File: rtl/force_release_if.sv
// force_release_if: command channel (valid/ready + op, mask, value, cycles) from sequencer to force_release_ctrl
interface force_release_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             valid;
  logic             ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] value;
  logic [CNT_W-1:0] cycles;
  modport master (output valid, op, mask, value, cycles, input ready);
  modport slave (input valid, op, mask, value, cycles, output ready);
endinterface

// File: rtl/force_release_ctrl.sv
// force_release_ctrl: queued force/release/timed-force driver; ports i_clk, i_rst_n, i_flush, cmd (slave), i_sig -> o_sig, o_force_en, o_force_value, o_release, o_busy, o_done
module force_release_ctrl #(
  parameter int WIDTH     = 8,
  parameter int CMD_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  force_release_if.slave   cmd,
  input  logic [WIDTH-1:0] i_sig,
  output logic [WIDTH-1:0] o_sig,
  output logic [WIDTH-1:0] o_force_en,
  output logic [WIDTH-1:0] o_force_value,
  output logic [WIDTH-1:0] o_release,
  output logic             o_busy,
  output logic             o_done
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam logic [1:0] OP_FORCE = 2'd0, OP_RELEASE = 2'd1, OP_TIMED = 2'd2, OP_REL_ALL = 2'd3;
  typedef enum logic {IDLE, HOLD} state_t;
  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] value;
    logic [CNT_W-1:0] cycles;
  } cmd_t;
  cmd_t             mem [CMD_DEPTH];
  cmd_t             head;
  logic [AW:0]      wr_ptr, rd_ptr;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] held;
  logic             empty, full, push, pop;
  assign empty     = wr_ptr == rd_ptr;
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd.ready = !full && !i_flush;
  assign push      = cmd.valid && cmd.ready;
  assign pop       = (state == IDLE) && !empty && !i_flush;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign o_busy    = !empty || (state != IDLE);
  assign o_sig     = (o_force_en & o_force_value) | (~o_force_en & i_sig);
  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd.op, cmd.mask, cmd.value, cmd.cycles};
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      state         <= IDLE;
      cnt           <= '0;
      held          <= '0;
      o_force_en    <= '0;
      o_force_value <= '0;
      o_release     <= '0;
      o_done        <= 1'b0;
    end else if (i_flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state      <= IDLE;
      cnt        <= '0;
      o_release  <= o_force_en;
      o_force_en <= '0;
      o_done     <= 1'b0;
    end else begin
      o_release <= '0;
      o_done    <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        o_done <= head.op != OP_TIMED;
        if (head.op == OP_FORCE || head.op == OP_TIMED) begin
          o_force_en    <= o_force_en | head.mask;
          o_force_value <= (o_force_value & ~head.mask) | (head.value & head.mask);
        end
        if (head.op == OP_RELEASE) begin
          o_force_en <= o_force_en & ~head.mask;
          o_release  <= o_force_en & head.mask;
        end
        if (head.op == OP_REL_ALL) begin
          o_force_en <= '0;
          o_release  <= o_force_en;
        end
        if (head.op == OP_TIMED) begin
          held  <= head.mask;
          cnt   <= (head.cycles == '0) ? '0 : head.cycles - 1'b1;
          state <= HOLD;
        end
      end else if (state == HOLD) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          o_force_en <= o_force_en & ~held;
          o_release  <= held & o_force_en;
          o_done     <= 1'b1;
          state      <= IDLE;
        end
      end
    end
  end
endmodule
